// File: rtl/instr_encode_loader.sv
// Encodes symbolic MIPS instruction descriptors into 32-bit words and streams them into instruction memory.
// Build with LOADER_CHECKSUM_EN defined to get a running XOR of written words on checksum.
module instr_encode_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26,
    input  logic              last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic              full,
    output logic [31:0]       pc_base,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic              last_q, last_d;

    logic [31:0]       enc_word;
    logic              enc_legal;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (kind)
            4'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
            4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
            4'd2:    enc_word = {6'b000000, rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
            4'd3:    enc_word = {6'b000100, rs, rt, imm16};
            4'd4:    enc_word = {6'b001111, 5'b00000, rt, imm16};
            4'd5:    enc_word = {6'b100011, rs, rt, imm16};
            4'd6:    enc_word = {6'b001101, rs, rt, imm16};
            4'd7:    enc_word = {6'b101011, rs, rt, imm16};
            4'd8:    enc_word = {6'b000010, target26};
            4'd9:    enc_word = {6'b000011, target26};
            4'd10:   enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100110};
            4'd11:   enc_word = {6'b111111, rs, rt, imm16};
            default: enc_legal = 1'b0;
        endcase
    end

    // start overrides every state, including a WRITE in flight.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        full_d  = full_q;
        last_d  = last_q;
        if (start) begin
            state_d = S_LOAD;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            full_d  = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            wdata_d = enc_word;
                            last_d  = last;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                            if (last) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    addr_d = addr_q + 1'b1;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (addr_q == ADDR_LAST) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            full_q  <= full_d;
            last_q  <= last_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start) begin
            csum_d = 32'h0;
        end else if (state_q == S_WRITE) begin
            csum_d = csum_q ^ wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 32'h0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

    // Strobes decode straight from the state register so an async reset drops im_we at once.
    assign im_we    = (state_q == S_WRITE);
    assign in_ready = (state_q == S_LOAD) && !start;
    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign count    = count_q;
    assign err      = err_q;
    assign full     = full_q;
    assign pc_base  = BASE_ADDR;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: a 1K-word instance for encoding/protocol and a 4-word instance for overflow.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Main instance (ADDR_W = 10)
    logic        start, in_valid, in_ready, last;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        im_we, cpu_hold, done, err, full;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata, pc_base, checksum;
    logic [10:0] count;

    instr_encode_loader #(.ADDR_W(10), .BASE_ADDR(32'h0000_3000)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .target26(target26), .last(last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count),
        .cpu_hold(cpu_hold), .done(done), .err(err), .full(full),
        .pc_base(pc_base), .checksum(checksum)
    );

    // Small instance (ADDR_W = 2) for the memory-full case
    logic        s_start, s_in_valid, s_in_ready, s_last;
    logic [3:0]  s_kind;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [15:0] s_imm16;
    logic [25:0] s_target26;
    logic        s_im_we, s_cpu_hold, s_done, s_err, s_full;
    logic [1:0]  s_im_addr;
    logic [31:0] s_im_wdata, s_pc_base, s_checksum;
    logic [2:0]  s_count;

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(32'h0000_3000)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .kind(s_kind), .rs(s_rs), .rt(s_rt), .rd(s_rd), .imm16(s_imm16), .target26(s_target26), .last(s_last),
        .im_we(s_im_we), .im_addr(s_im_addr), .im_wdata(s_im_wdata), .count(s_count),
        .cpu_hold(s_cpu_hold), .done(s_done), .err(s_err), .full(s_full),
        .pc_base(s_pc_base), .checksum(s_checksum)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [41:0] exp_q[$];
    logic [41:0] s_exp_q[$];
    logic [9:0]  exp_addr;
    logic [31:0] acc;
    logic        prev_we = 1'b0;
    logic [41:0] mon_e, s_mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cs_exp();
`ifdef LOADER_CHECKSUM_EN
        return acc;
`else
        return 32'h0;
`endif
    endfunction

    // Scoreboard: every write strobe must match the oldest expected {addr, word}
    always @(negedge clk) begin
        if (im_we) begin
            chk("we_gap", {31'b0, prev_we}, 32'h0);
            chk("rdy_in_write", {31'b0, in_ready}, 32'h0);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'h1, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("im_addr", {22'b0, im_addr}, {22'b0, mon_e[41:32]});
                chk("im_wdata", im_wdata, mon_e[31:0]);
                $display("write IM[%0d] = %08h", im_addr, im_wdata);
            end
        end
        prev_we = im_we;
    end

    always @(negedge clk) begin
        if (s_im_we) begin
            if (s_exp_q.size() == 0) begin
                chk("s_unexpected_we", 32'h1, 32'h0);
            end else begin
                s_mon_e = s_exp_q.pop_front();
                chk("s_im_addr", {30'b0, s_im_addr}, {22'b0, s_mon_e[41:32]});
                chk("s_im_wdata", s_im_wdata, s_mon_e[31:0]);
                $display("small write IM[%0d] = %08h", s_im_addr, s_im_wdata);
            end
        end
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_we"},    {31'b0, im_we},    32'h0);
        chk({pfx, "_addr"},  {22'b0, im_addr},  32'h0);
        chk({pfx, "_wdata"}, im_wdata,          32'h0);
        chk({pfx, "_count"}, {21'b0, count},    32'h0);
        chk({pfx, "_hold"},  {31'b0, cpu_hold}, 32'h1);
        chk({pfx, "_done"},  {31'b0, done},     32'h0);
        chk({pfx, "_err"},   {31'b0, err},      32'h0);
        chk({pfx, "_full"},  {31'b0, full},     32'h0);
        chk({pfx, "_rdy"},   {31'b0, in_ready}, 32'h0);
        chk({pfx, "_cs"},    checksum,          32'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        #1 chk("rdy_at_start", {31'b0, in_ready}, 32'h0);
        @(negedge clk);
        start    = 1'b0;
        exp_addr = '0;
        acc      = 32'h0;
        chk("st_count", {21'b0, count}, 32'h0);
        chk("st_addr",  {22'b0, im_addr}, 32'h0);
        chk("st_flags", {28'b0, done, err, full, cpu_hold}, 32'h1);
        chk("st_cs",    checksum, 32'h0);
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] a_rs, input logic [4:0] a_rt,
                        input logic [4:0] a_rd, input logic [15:0] a_imm, input logic [25:0] a_tgt,
                        input logic a_last, input logic a_cont, input logic [31:0] exp_word);
        int n;
        logic legal;
        legal = (k < 4'd12);
        @(negedge clk);
        kind = k; rs = a_rs; rt = a_rt; rd = a_rd; imm16 = a_imm; target26 = a_tgt; last = a_last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            in_valid = 1'b0;
            return;
        end
        $display("send kind=%0d last=%0b expect %08h", k, a_last, exp_word);
        if (legal) begin
            exp_q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 1'b1;
            acc      = acc ^ exp_word;
        end
        @(posedge clk);
        if (!legal) begin
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk("illegal_nowe", {31'b0, im_we}, 32'h0);
        end else begin
            @(negedge clk);
            chk("lat_we", {31'b0, im_we}, 32'h1);
            if (!a_cont) in_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; imm16 = '0; target26 = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_last = 1'b0;
        s_kind = '0; s_rs = '0; s_rt = '0; s_rd = '0; s_imm16 = '0; s_target26 = '0;
        exp_addr = '0; acc = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        chk("pc_base", pc_base, 32'h0000_3000);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        // Program: addu, ori, jal(last)
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0022_1821);
        send(4'd6, 5'd0, 5'd4, 5'd0, 16'h1234, 26'h0, 1'b0, 1'b0, 32'h3404_1234);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00, 1'b1, 1'b0, 32'h0C00_0C00);
        @(negedge clk);
        chk("p1_count", {21'b0, count}, 32'd3);
        chk("p1_done",  {31'b0, done}, 32'h1);
        chk("p1_hold",  {31'b0, cpu_hold}, 32'h0);
        chk("p1_cs",    checksum, cs_exp());

        // Back-to-back lw/sw with in_valid held high
        pulse_start();
        send(4'd5, 5'd5, 5'd6, 5'd0, 16'hFFFC, 26'h0, 1'b0, 1'b1, 32'h8CA6_FFFC);
        send(4'd7, 5'd5, 5'd6, 5'd0, 16'h0004, 26'h0, 1'b1, 1'b0, 32'hACA6_0004);
        @(negedge clk);
        chk("p2_count", {21'b0, count}, 32'd2);
        chk("p2_done",  {31'b0, done}, 32'h1);
        chk("p2_cs",    checksum, cs_exp());

        // Illegal kind followed by beq(last)
        pulse_start();
        send(4'd13, 5'd1, 5'd2, 5'd3, 16'h5555, 26'h0, 1'b0, 1'b0, 32'h0);
        chk("p3_err_early", {31'b0, err}, 32'h1);
        send(4'd3, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, 1'b0, 32'h1022_FFFF);
        @(negedge clk);
        chk("p3_err",   {31'b0, err}, 32'h1);
        chk("p3_count", {21'b0, count}, 32'd1);
        chk("p3_done",  {31'b0, done}, 32'h1);
        chk("p3_cs",    checksum, cs_exp());

        // Forced-zero fields and remaining opcodes
        pulse_start();
        send(4'd2,  5'd31, 5'd7, 5'd9, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h03E0_0008);
        send(4'd4,  5'd5,  5'd8, 5'd1, 16'hABCD, 26'h0, 1'b0, 1'b1, 32'h3C08_ABCD);
        send(4'd11, 5'd3,  5'd0, 5'd0, 16'h0010, 26'h0, 1'b0, 1'b1, 32'hFC60_0010);
        send(4'd8,  5'd0,  5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 1'b0, 32'h0BFF_FFFF);
        @(negedge clk);
        chk("p4_count", {21'b0, count}, 32'd4);
        chk("p4_done",  {31'b0, done}, 32'h1);

        // Async reset in the WRITE cycle of word 1
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1821);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0022_1823);
        #2 reset = 1'b1;
        #1 chk("mid_rst_we", {31'b0, im_we}, 32'h0);
        chk_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        exp_addr = '0;
        acc = 32'h0;
        pulse_start();
        send(4'd10, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0022_1826);
        @(negedge clk);
        chk("p5_count", {21'b0, count}, 32'd1);
        chk("p5_done",  {31'b0, done}, 32'h1);
        chk("p5_cs",    checksum, cs_exp());

        // Memory-full on the 4-word instance: five descriptors, no last
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_kind = 4'd6; s_rs = 5'd0; s_rt = 5'(i); s_imm16 = 16'(i); s_last = 1'b0;
            s_in_valid = 1'b1;
            if (i < 4) begin
                n = 0;
                while (!s_in_ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!s_in_ready) chk("s_accept_timeout", 32'h0, 32'h1);
                s_exp_q.push_back({10'(i), 32'h3400_0000 | (32'(i) << 16) | 32'(i)});
                $display("small send ori #%0d", i);
                @(posedge clk);
            end else begin
                repeat (6) begin
                    chk("s_no_accept", {31'b0, s_in_ready}, 32'h0);
                    @(negedge clk);
                end
            end
        end
        s_in_valid = 1'b0;
        chk("s_full",  {31'b0, s_full}, 32'h1);
        chk("s_done",  {31'b0, s_done}, 32'h1);
        chk("s_count", {29'b0, s_count}, 32'd4);
        chk("s_addr_wrap", {30'b0, s_im_addr}, 32'h0);
        chk("s_q_empty", 32'(s_exp_q.size()), 32'h0);
        chk("q_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
